// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bus bundle between two requesters, the arbiter and one shared RAM
// Signals: p0_*/p1_* requester address, write data, read/write request pulses, read data and ack pulses;
//          mem_* RAM address, write data, request pulses, read data and acks.
// Modports: slave = arbiter view (serves requesters, drives RAM), master = requester/RAM view.
interface ram_arbiter_if;
  logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata, p0_rdata, p1_rdata;
  logic p0_read_req, p1_read_req, p0_write_req, p1_write_req;
  logic p0_read_ack, p1_read_ack, p0_write_ack, p1_write_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic mem_read_req, mem_write_req, mem_read_ack, mem_write_ack;
  modport slave (
    input p0_addr, p1_addr, p0_wdata, p1_wdata,
    input p0_read_req, p1_read_req, p0_write_req, p1_write_req,
    output p0_rdata, p1_rdata, p0_read_ack, p1_read_ack, p0_write_ack, p1_write_ack,
    output mem_addr, mem_wdata, mem_read_req, mem_write_req,
    input mem_rdata, mem_read_ack, mem_write_ack
  );
  modport master (
    output p0_addr, p1_addr, p0_wdata, p1_wdata,
    output p0_read_req, p1_read_req, p0_write_req, p1_write_req,
    input p0_rdata, p1_rdata, p0_read_ack, p1_read_ack, p0_write_ack, p1_write_ack,
    input mem_addr, mem_wdata, mem_read_req, mem_write_req,
    output mem_rdata, mem_read_ack, mem_write_ack
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter giving two requesters single-slot access to one shared RAM
// Ports: clk; rst_n (asynchronous, active-low); bus (ram_arbiter_if.slave, requester and RAM sides);
//        owner (requester of current/last transaction); busy (transaction in flight);
//        timeout_err (one-cycle pulse when a transaction is aborted).
// Option: define RAM_ARBITER_TIMEOUT_EN to abort a WAIT lasting TIMEOUT_CYCLES cycles, returning
//         TIMEOUT_DATA on reads; otherwise WAIT lasts until the RAM acks and timeout_err stays 0.
module ram_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_DATA = 32'h0badf00d
) (
  input logic clk,
  input logic rst_n,
  ram_arbiter_if.slave bus,
  output logic owner,
  output logic busy,
  output logic timeout_err
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state;
  logic [1:0] rd, wr, v, w, clr, rack, wack;
  logic [1:0][31:0] addr, wdata, a, d, rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic mem_rd, mem_wr, win, grant, hit, tmo, fin;
  assign rd = {bus.p1_read_req, bus.p0_read_req};
  assign wr = {bus.p1_write_req, bus.p0_write_req};
  assign addr = {bus.p1_addr, bus.p0_addr};
  assign wdata = {bus.p1_wdata, bus.p0_wdata};
  assign bus.p0_rdata = rdata[0];
  assign bus.p1_rdata = rdata[1];
  assign bus.p0_read_ack = rack[0];
  assign bus.p1_read_ack = rack[1];
  assign bus.p0_write_ack = wack[0];
  assign bus.p1_write_ack = wack[1];
  assign bus.mem_addr = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_read_req = mem_rd;
  assign bus.mem_write_req = mem_wr;
  // with both slots pending the requester that did not own the last transaction wins
  assign win = &v ? ~owner : v[1];
  assign grant = state == IDLE && |v;
  // only an ack of the type that was issued ends the transaction
  assign hit = state == WAIT && (w[owner] ? bus.mem_write_ack : bus.mem_read_ack);
  assign fin = hit | tmo;
  assign clr = {fin & owner, fin & ~owner};
`ifdef RAM_ARBITER_TIMEOUT_EN
  logic [7:0] cnt;
  assign tmo = state == WAIT && !hit && cnt == 8'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      cnt <= state == WAIT ? cnt + 8'd1 : 8'd0;
      timeout_err <= tmo;
    end
`else
  assign tmo = 1'b0;
  assign timeout_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      v <= '0;
      w <= '0;
      a <= '0;
      d <= '0;
      rdata <= '0;
      rack <= '0;
      wack <= '0;
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      owner <= 1'b1;
      busy <= 1'b0;
    end else begin
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      rack <= '0;
      wack <= '0;
      // a slot freed at this edge can take a new request at the same edge; write wins over read
      for (int i = 0; i < 2; i++)
        if ((rd[i] | wr[i]) & (clr[i] | ~v[i])) begin
          v[i] <= 1'b1;
          w[i] <= wr[i];
          a[i] <= addr[i];
          d[i] <= wdata[i];
        end else if (clr[i]) v[i] <= 1'b0;
      if (grant) begin
        mem_addr <= a[win];
        mem_wdata <= d[win];
        mem_rd <= ~w[win];
        mem_wr <= w[win];
        owner <= win;
        busy <= 1'b1;
        state <= WAIT;
      end else if (fin) begin
        if (!w[owner]) rdata[owner] <= hit ? bus.mem_rdata : TIMEOUT_DATA;
        rack[owner] <= ~w[owner];
        wack[owner] <= w[owner];
        busy <= 1'b0;
        state <= IDLE;
      end
    end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, max cycles in WAIT before abort (8-bit counter; legal 1..255).
REQ-002 Parameter: TIMEOUT_DATA, 32'h0badf00d, read data returned on timeout abort.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  reset; asynchronous, active-low.
REQ-005 p0_addr, p1_addr  input  32 each  requester 0 (CPU) / requester 1 (aux) address.
REQ-006 p0_wdata, p1_wdata  input  32 each  write data.
REQ-007 p0_read_req, p1_read_req, p0_write_req, p1_write_req  input  1 each  single-cycle request pulses.
REQ-008 p0_rdata, p1_rdata  output  32 each  registered read data.
REQ-009 p0_read_ack, p1_read_ack, p0_write_ack, p1_write_ack  output  1 each  single-cycle completion pulses.
REQ-010 mem_addr, mem_wdata  output  32 each  shared RAM address / write data.
REQ-011 mem_read_req, mem_write_req  output  1 each  single-cycle RAM request pulses.
REQ-012 mem_rdata  input  32  RAM read data; mem_read_ack, mem_write_ack  input  1 each  RAM acknowledges.
REQ-013 owner  output  1  requester granted in current/last transaction; busy  output  1  high in WAIT.
REQ-014 timeout_err  output  1  single-cycle pulse on timeout abort.

Function
REQ-015 Each requester SHALL have one pending slot {valid, is_write, addr, wdata}, loaded at the edge sampling a request pulse while the slot is empty.
REQ-016 Request pulse while slot valid SHALL be ignored (slot unchanged).
REQ-017 read_req and write_req in the same cycle from one requester SHALL load a write; read dropped.
REQ-018 Request pulse at the edge that clears the same requester's slot SHALL be loaded (clear then load).
REQ-019 States: IDLE, WAIT only; reset enters IDLE.
REQ-020 IDLE, no valid slot: outputs hold, mem_*_req low.
REQ-021 IDLE, one valid slot: grant it; both valid: grant requester != owner (round-robin); first arbitration after reset grants requester 0.
REQ-022 On grant edge: mem_addr/mem_wdata <= slot fields, exactly one of mem_read_req/mem_write_req <= 1, owner <= winner, busy <= 1, state <= WAIT, timeout counter <= 0.
REQ-023 mem_*_req SHALL be high exactly one cycle; cleared on the following edge.
REQ-024 WAIT: ack of the issued type sampled high -> winner rdata <= mem_rdata (reads only), winner's matching ack <= 1 for one cycle, winner slot cleared, busy <= 0, state <= IDLE.
REQ-025 Acks of the wrong type or in IDLE SHALL be ignored.
REQ-026 Earliest completion: request edge E0, grant E1, ack sampled E2, requester ack high after E2; next grant no earlier than E3.
REQ-027 mem_addr, mem_wdata, p*_rdata SHALL hold until next overwrite.
REQ-028 Non-owner rdata and acks SHALL not change during a transaction.

Reset
REQ-029 Reset low SHALL immediately: state IDLE, slots invalid, all req/ack/busy/timeout_err 0, mem_addr, mem_wdata, p0_rdata, p1_rdata 0, owner 1 (so requester 0 wins first), counter 0.
REQ-030 Reset mid-WAIT SHALL abandon the transaction; a late mem ack after deassertion SHALL be ignored.

Configuration
REQ-031 Macro RAM_ARBITER_TIMEOUT_EN defined: WAIT counter increments each cycle without a valid ack; at count == TIMEOUT_CYCLES-1 with no ack, complete as REQ-024 with rdata TIMEOUT_DATA (reads), pulse timeout_err, return IDLE.
REQ-032 Macro undefined: no counter, WAIT persists until ack, timeout_err tied 0.

Verification
REQ-033 p0 read addr 0x10, RAM acks next cycle data 0x12345678 -> mem_read_req one cycle addr 0x10, p0_read_ack one cycle, p0_rdata 0x12345678, owner 0.
REQ-034 p0 write and p1 read same cycle after reset -> p0 write first, then p1 read; then both again -> round-robin grants p0 (owner was 1).
REQ-035 p1 read_req+write_req same cycle addr 0x40 wdata 0xA5A5A5A5 -> only mem_write_req, p1_write_ack; no read ack.
REQ-036 p0 second read pulse while first pending -> exactly one mem_read_req, one p0_read_ack.
REQ-037 TIMEOUT_EN, TIMEOUT_CYCLES 4, no RAM ack -> timeout_err after 4 WAIT cycles, p0_rdata 0x0badf00d, p0_read_ack; undefined build: busy stays high.
REQ-038 Reset low during WAIT then RAM ack after release -> no requester ack, state IDLE, all outputs at reset values.
